sort4_ctrl: RTL and testbench
=============================

# sort4_ctrl

Sequential sorting controller built around a single shared 4-bit unsigned greater-than comparator. It accepts N 4-bit values over a valid/ready input stream and stores them in an internal buffer. It sorts the buffer in ascending order by scheduling exactly one compare-and-swap per clock through the comparator, then streams the sorted values out over a valid/ready output stream. The block is the scheduling layer that time-shares the comparator datapath between all buffer-entry pairs.

## Interface
- N, default 4, number of entries per batch; legal range 2..8.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle; a transfer occurs when in_valid && in_ready at the clk edge.
- in_data  input  4  unsigned value to load.
- out_valid  output  1  out_data holds a sorted element.
- out_ready  input  1  downstream accepts out_data; a transfer occurs when out_valid && out_ready at the clk edge.
- out_data  output  4  current sorted element, smallest first.
- out_last  output  1  high with out_valid when out_data is element N-1.
- busy  output  1  high in SORT and OUT states.

## Operation
- Storage and counters:
  - buf[0..N-1], 4 bits each.
  - Index counters are sized to ceil(log2(N)) bits.
  - Pass counter p and pair counter j are sized to hold 0..N-2.
- FSM states are LOAD, SORT and OUT. LOAD is the reset state.
- LOAD:
  - in_ready=1, out_valid=0, busy=0.
  - Each input transfer writes buf[k], where k counts 0..N-1.
  - On the transfer with k==N-1: go to SORT, clear k, p and j.
- SORT:
  - in_ready=0, out_valid=0, busy=1.
  - Each cycle, the comparator evaluates buf[j] > buf[j+1] as a 4-bit unsigned compare.
  - If greater, swap the two entries at the edge. Otherwise leave both unchanged.
  - Equal values never swap, so the sort is stable.
  - Schedule:
    - If j < N-2-p, then j increments.
    - Otherwise j returns to 0 and p increments.
    - After the compare with p==N-2 and j==0, go to OUT with k=0.
  - The schedule is fixed: always N(N-1)/2 compares, with no early exit on already-sorted data.
- OUT:
  - out_valid=1, out_data=buf[k], out_last=(k==N-1), busy=1, in_ready=0.
  - Each output transfer increments k.
  - The transfer with out_last=1 clears k and returns to LOAD.
  - While out_ready=0, out_data and out_last hold steady.
- Inputs outside LOAD and output handshakes outside OUT are ignored; no data is lost or duplicated.
- Reset values, applied immediately on rst_n low and independent of clk:
  - state=LOAD; k, p, j=0; buf all 0.
  - in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Reset during LOAD, SORT or OUT discards the batch. The first input transfer after rst_n rises is entry 0 of a new batch.

## Timing
- in_ready, out_valid, out_last and busy decode from the state register only. There is no combinational path from in_valid or out_ready to any output.
- Let edge E0 be the edge that accepts the last input of a batch.
  - SORT compares occur at edges E1..E(N(N-1)/2); for N=4 these are E1..E6.
  - out_valid rises after the last compare edge. For N=4 it is high in the cycle following E6.
- With out_ready held at 1, the N elements transfer on N consecutive edges.
- in_ready=1 in the cycle directly after the out_last transfer. The next batch can start in that cycle with no bubble.
- Minimum batch period for N=4 with no stalls: 4 load + 6 sort + 4 out = 14 cycles.

## Test plan
- Reset check: assert rst_n=0 mid-cycle -> outputs immediately show in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Basic sort (N=4): load 9,3,15,0 back-to-back -> out_valid rises 6 cycles after the last accept; outputs are 0,3,9,15 with out_last only on 15; in_ready=1 the cycle after the final transfer.
- Duplicates and order extremes:
  - load 5,5,2,5 -> outputs 2,5,5,5.
  - load 15,14,13,12 and 0,1,2,3 -> outputs ascending, with an identical 6-cycle sort latency.
- Backpressure and ignored input:
  - hold out_ready=0 for 3 cycles while element 1 is presented -> out_data and out_last remain stable; exactly 4 transfers occur.
  - hold in_valid=1 throughout SORT and OUT -> no extra entries are captured.
- Reset mid-operation: assert rst_n during the 3rd SORT cycle of batch 8,1,7,2 -> reset values appear at once; a new batch 4,0,4,1 afterwards outputs 0,1,4,4.
- Gapped input and back-to-back batches: load with in_valid gaps of 0–2 cycles, then start the next batch in the cycle after out_last -> both batches sort correctly with no lost or duplicated entries.

Source files
------------

// File: rtl/sort4_ctrl.sv
// Batch sorter: loads N 4-bit values, bubble-sorts them through one shared
// greater-than comparator (one compare-and-swap per clock), then streams them out.
module sort4_ctrl #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] LAST_P   = IW'(N - 2);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_OUT
  } state_t;

  state_t        state_q;
  logic [IW-1:0] k_q;
  logic [IW-1:0] p_q;
  logic [IW-1:0] j_q;
  logic [3:0]    buf_q [N];

  logic [IW-1:0] j1_d;
  logic          swap_d;
  logic          pass_end_d;

  // Shared comparator and bubble-pass schedule decode
  always_comb begin
    j1_d       = j_q + 1'b1;
    swap_d     = buf_q[j_q] > buf_q[j1_d];
    pass_end_d = (j_q >= (LAST_P - p_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      k_q     <= '0;
      p_q     <= '0;
      j_q     <= '0;
      buf_q   <= '{default: '0};
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            buf_q[k_q] <= in_data;
            if (k_q == LAST_IDX) begin
              state_q <= S_SORT;
              k_q     <= '0;
              p_q     <= '0;
              j_q     <= '0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        S_SORT: begin
          if (swap_d) begin
            buf_q[j_q]  <= buf_q[j1_d];
            buf_q[j1_d] <= buf_q[j_q];
          end
          if (!pass_end_d) begin
            j_q <= j1_d;
          end else begin
            j_q <= '0;
            if (p_q == LAST_P) begin
              state_q <= S_OUT;
              k_q     <= '0;
              p_q     <= '0;
            end else begin
              p_q <= p_q + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (k_q == LAST_IDX) begin
              state_q <= S_LOAD;
              k_q     <= '0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Handshake outputs depend only on registered state, never on in_valid/out_ready
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_LOAD);
  assign out_last  = (state_q == S_OUT) && (k_q == LAST_IDX);
  assign out_data  = (state_q == S_OUT) ? buf_q[k_q] : 4'h0;

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl (N=4): inputs driven and outputs sampled on
// the falling clock edge, expected sorted batches computed by hand.
module tb_sort4_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;

  int checks;
  int passes;

  sort4_ctrl #(.N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1, "watchdog expired");
  end

  // Drive one value (after gap idle cycles); returns at the negedge after acceptance.
  task automatic send(input logic [3:0] v, input int gap, output bit ok);
    int n;
    ok = 1'b1;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) ok = 1'b0;
    @(negedge clk);
  endtask

  // vals: entry i at [4i+:4]; gaps: idle cycles before entry i at [2i+:2]
  task automatic load4(input logic [15:0] vals, input logic [7:0] gaps, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vals[4*i +: 4], int'(gaps[2*i +: 2]), o);
      if (!o) ok = 1'b0;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Collect 4 elements with out_ready high; element i at d[4i+:4], out_last at l[i].
  task automatic recv(output logic [15:0] d, output logic [3:0] l, output bit ok);
    int n;
    ok = 1'b1;
    d  = '0;
    l  = '0;
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) ok = 1'b0;
      d[4*i +: 4] = out_data;
      l[i]        = out_last;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int lat;
    rst_n = 1'b0;
    #3;
    checks++; if ({in_ready, out_valid, out_data, out_last, busy} !== 8'b1_0_0000_0_0)
      $display("FAIL reset_por: got %b required 10000000", {in_ready, out_valid, out_data, out_last, busy});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    load4(16'h4321, 8'h00, ok);
    in_valid = 1'b0;
    wait_out(lat);
    checks++; if ({out_valid, out_data, busy} !== 6'b1_0001_1)
      $display("FAIL reset_preout: got %b required 100011", {out_valid, out_data, busy});
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, out_data, out_last, busy} !== 8'b1_0_0000_0_0)
      $display("FAIL reset_async: got %b required 10000000", {in_ready, out_valid, out_data, out_last, busy});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sort();
    bit ok, ok2;
    int lat;
    logic [15:0] d;
    logic [3:0] l;
    load4(16'h0F39, 8'h00, ok);
    in_valid = 1'b0;
    checks++; if (ok !== 1'b1) $display("FAIL basic_load: accepted %b required 1", ok); else passes++;
    checks++; if ({in_ready, busy, out_valid} !== 3'b010)
      $display("FAIL basic_sortstate: got %b required 010", {in_ready, busy, out_valid});
    else passes++;
    wait_out(lat);
    checks++; if (lat !== 6) $display("FAIL basic_latency: got %0d required 6", lat); else passes++;
    recv(d, l, ok2);
    checks++; if (d !== 16'hF930 || ok2 !== 1'b1)
      $display("FAIL basic_data: got %h ok=%b required f930 ok=1", d, ok2);
    else passes++;
    checks++; if (l !== 4'b1000) $display("FAIL basic_last: got %b required 1000", l); else passes++;
    checks++; if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL basic_after: got %b required 100", {in_ready, out_valid, busy});
    else passes++;
  endtask

  task automatic test_duplicates_extremes();
    bit ok, ok2;
    int lat;
    logic [15:0] d;
    logic [3:0] l;
    logic [15:0] vin [3];
    logic [15:0] vexp [3];
    vin[0] = 16'h5255; vexp[0] = 16'h5552;
    vin[1] = 16'hCDEF; vexp[1] = 16'hFEDC;
    vin[2] = 16'h3210; vexp[2] = 16'h3210;
    for (int t = 0; t < 3; t++) begin
      load4(vin[t], 8'h00, ok);
      in_valid = 1'b0;
      wait_out(lat);
      checks++; if (lat !== 6 || ok !== 1'b1)
        $display("FAIL ext%0d_latency: got %0d ok=%b required 6 ok=1", t, lat, ok);
      else passes++;
      recv(d, l, ok2);
      checks++; if (d !== vexp[t] || l !== 4'b1000 || ok2 !== 1'b1)
        $display("FAIL ext%0d_data: got %h last=%b required %h last=1000", t, d, l, vexp[t]);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [15:0] d;
    logic [3:0] l;
    load4(16'hA1C6, 8'h00, ok);
    in_valid = 1'b0;
    wait_out(lat);
    d = '0;
    l = '0;
    d[3:0] = out_data; l[0] = out_last;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if ({out_valid, out_data, out_last} !== 6'b1_0110_0)
        $display("FAIL bp_hold%0d: got %b required 101100", c, {out_valid, out_data, out_last});
      else passes++;
      @(negedge clk);
    end
    for (int i = 1; i < 4; i++) begin
      d[4*i +: 4] = out_data;
      l[i] = out_last;
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (d !== 16'hCA61 || l !== 4'b1000)
      $display("FAIL bp_data: got %h last=%b required ca61 last=1000", d, l);
    else passes++;
    checks++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_count: got valid,ready=%b required 01", {out_valid, in_ready});
    else passes++;
  endtask

  task automatic test_ignored_input();
    bit ok, ok2;
    int lat;
    logic [15:0] d;
    logic [3:0] l;
    load4(16'h484A, 8'h00, ok);
    in_data = 4'hD;
    wait_out(lat);
    checks++; if (lat !== 6) $display("FAIL ign_latency: got %0d required 6", lat); else passes++;
    recv(d, l, ok2);
    in_valid = 1'b0;
    checks++; if (d !== 16'hA844 || l !== 4'b1000)
      $display("FAIL ign_data: got %h last=%b required a844 last=1000", d, l);
    else passes++;
    load4(16'h0111, 8'h00, ok);
    in_valid = 1'b0;
    wait_out(lat);
    recv(d, l, ok2);
    checks++; if (d !== 16'h1110 || l !== 4'b1000 || lat !== 6)
      $display("FAIL ign_next: got %h last=%b lat=%0d required 1110 last=1000 lat=6", d, l, lat);
    else passes++;
  endtask

  task automatic test_reset_mid_sort();
    bit ok, ok2;
    int lat;
    logic [15:0] d;
    logic [3:0] l;
    load4(16'h2718, 8'h00, ok);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, out_data, out_last, busy} !== 8'b1_0_0000_0_0)
      $display("FAIL rstmid_values: got %b required 10000000", {in_ready, out_valid, out_data, out_last, busy});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    load4(16'h1404, 8'h00, ok);
    in_valid = 1'b0;
    wait_out(lat);
    recv(d, l, ok2);
    checks++; if (d !== 16'h4410 || l !== 4'b1000 || lat !== 6)
      $display("FAIL rstmid_batch: got %h last=%b lat=%0d required 4410 last=1000 lat=6", d, l, lat);
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    int lat;
    logic [15:0] d;
    logic [3:0] l;
    load4(16'h3B07, 8'b00_01_10_00, ok);
    in_valid = 1'b0;
    wait_out(lat);
    recv(d, l, ok2);
    checks++; if (d !== 16'hB730 || l !== 4'b1000 || lat !== 6)
      $display("FAIL b2b_first: got %h last=%b lat=%0d required b730 last=1000 lat=6", d, l, lat);
    else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b required 1", in_ready); else passes++;
    load4(16'h9E22, 8'b00_10_00_00, ok);
    in_valid = 1'b0;
    wait_out(lat);
    recv(d, l, ok2);
    checks++; if (d !== 16'hE922 || l !== 4'b1000 || ok !== 1'b1)
      $display("FAIL b2b_second: got %h last=%b required e922 last=1000", d, l);
    else passes++;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    test_reset();
    test_basic_sort();
    test_duplicates_extremes();
    test_backpressure();
    test_ignored_input();
    test_reset_mid_sort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
